cache_req_arbiter: RTL and testbench

Round-robin front-end that shares the single-port set-associative cache (12-bit byte address, 32-bit data) between `NUM_REQ` requesters. It accepts one request at a time over valid/ready and drives the cache read/write enables and address/data. It waits for the cache response and returns read data to the owning requester. It also keeps saturating hit/miss statistics and flags cache protocol violations.

---
 rtl/cache_pkg.sv | 16 +
 rtl/cache_req_arbiter_if.sv | 29 ++
 rtl/cache_req_arbiter_rr_picker.sv | 28 ++
 rtl/cache_req_arbiter.sv | 105 ++++++++++
 tb/tb_cache_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache request front-end.
package cache_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int SET_W  = 3;
    localparam int OFF_W  = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } cache_req_t;
endpackage

// File: rtl/cache_req_arbiter_if.sv
// Arbiter-to-cache request/response bus.
interface cache_req_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cache_req_valid;
    logic              cache_req_ready;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_read_en;
    logic              cache_write_en;
    logic [DATA_W-1:0] cache_wdata;
    logic              cache_rsp_valid;
    logic [DATA_W-1:0] cache_rsp_data;
    logic              cache_rsp_hit;

    modport master (
        output cache_req_valid, cache_addr, cache_read_en,
        output cache_write_en, cache_wdata,
        input  cache_req_ready, cache_rsp_valid,
        input  cache_rsp_data, cache_rsp_hit
    );

    modport slave (
        input  cache_req_valid, cache_addr, cache_read_en,
        input  cache_write_en, cache_wdata,
        output cache_req_ready, cache_rsp_valid,
        output cache_rsp_data, cache_rsp_hit
    );
endinterface

// File: rtl/cache_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rrPtr.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] reqValid,
    input  logic [PTR_W-1:0]   rrPtr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);
    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rrPtr) + k) % NUM_REQ;
            if (!found && reqValid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
    end
endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin front-end sharing one single-port cache between NUM_REQ requesters.
module cache_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    cache_req_arbiter_if.master       cache,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt,
    output logic                      proto_err
);
    import cache_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state;
    logic [PTR_W-1:0]   rrPtr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   winner;
    logic [NUM_REQ-1:0] grant;
    logic               anyValid;

    rr_picker #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) picker (
        .reqValid(req_valid),
        .rrPtr   (rrPtr),
        .grant   (grant),
        .winner  (winner),
        .found   (anyValid)
    );

    // Gated by rst so no accept strobe leaks out while reset is held.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            rrPtr                <= '0;
            owner                <= '0;
            rsp_valid            <= '0;
            rsp_rdata            <= '0;
            hit_cnt              <= '0;
            miss_cnt             <= '0;
            proto_err            <= 1'b0;
            cache.cache_req_valid <= 1'b0;
            cache.cache_read_en  <= 1'b0;
            cache.cache_write_en <= 1'b0;
            cache.cache_addr     <= '0;
            cache.cache_wdata    <= '0;
        end else begin
            rsp_valid <= '0;
            // A response outside WAIT has no owner; flag it and drop it.
            if (cache.cache_rsp_valid && state != WAIT) begin
                proto_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (anyValid) begin
                        owner                 <= winner;
                        cache.cache_addr      <= req_addr[winner*ADDR_W +: ADDR_W];
                        cache.cache_wdata     <= req_wdata[winner*DATA_W +: DATA_W];
                        cache.cache_read_en   <= !req_we[winner];
                        cache.cache_write_en  <= req_we[winner];
                        cache.cache_req_valid <= 1'b1;
                        rrPtr <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache.cache_req_ready) begin
                        cache.cache_req_valid <= 1'b0;
                        cache.cache_read_en   <= 1'b0;
                        cache.cache_write_en  <= 1'b0;
                        state                 <= WAIT;
                    end
                end
                WAIT: begin
                    if (cache.cache_rsp_valid) begin
                        rsp_rdata        <= cache.cache_rsp_data;
                        rsp_valid[owner] <= 1'b1;
                        if (cache.cache_rsp_hit) begin
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a hand-driven cache stub.
module tb_cache_req_arbiter;
    localparam int NR = 2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]   req_we;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [CW-1:0]   hit_cnt;
    logic [CW-1:0]   miss_cnt;
    logic            proto_err;

    int nTests = 0;
    int nFail  = 0;

    cache_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cbus ();

    cache_req_arbiter #(
        .NUM_REQ(NR),
        .ADDR_W (AW),
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_we   (req_we),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .cache    (cbus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req_valid = '0;
        cbus.cache_req_ready = 1'b0;
        cbus.cache_rsp_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Cache stub: accept in the ISSUE cycle, answer the cycle after.
    task automatic serve(input logic hit, input logic [DW-1:0] data);
        cbus.cache_req_ready = 1'b1;
        cyc();
        cbus.cache_req_ready = 1'b0;
        cbus.cache_rsp_valid = 1'b1;
        cbus.cache_rsp_data  = data;
        cbus.cache_rsp_hit   = hit;
        cyc();
        cbus.cache_rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] expG [4];
        expG = '{2'b01, 2'b10, 2'b01, 2'b10};
        req_addr  = '0;
        req_we    = '0;
        req_wdata = '0;
        cbus.cache_rsp_data = '0;
        cbus.cache_rsp_hit  = 1'b0;

        // Reset values, including no accept while rst is held
        rst = 1'b1;
        req_valid = 2'b11;
        cbus.cache_req_ready = 1'b0;
        cbus.cache_rsp_valid = 1'b0;
        cyc();
        cyc();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_creq_valid", cbus.cache_req_valid, 0);
        check("rst_read_en", cbus.cache_read_en, 0);
        check("rst_write_en", cbus.cache_write_en, 0);
        check("rst_addr", cbus.cache_addr, 0);
        check("rst_wdata", cbus.cache_wdata, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_miss", miss_cnt, 0);
        check("rst_perr", proto_err, 0);
        req_valid = '0;
        rst = 1'b0;

        // Single read by requester 0
        req_addr[0 +: AW] = 12'h022;
        req_we[0] = 1'b0;
        req_valid = 2'b01;
        #1;
        check("rd_grant", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        check("rd_creq_valid", cbus.cache_req_valid, 1);
        check("rd_addr", cbus.cache_addr, 12'h022);
        check("rd_read_en", cbus.cache_read_en, 1);
        check("rd_write_en", cbus.cache_write_en, 0);
        cbus.cache_req_ready = 1'b1;
        cyc();
        cbus.cache_req_ready = 1'b0;
        check("rd_wait_creq", cbus.cache_req_valid, 0);
        cbus.cache_rsp_valid = 1'b1;
        cbus.cache_rsp_data  = 32'd14;
        cbus.cache_rsp_hit   = 1'b0;
        check("rd_no_early_rsp", rsp_valid, 0);
        cyc();
        cbus.cache_rsp_valid = 1'b0;
        check("rd_rsp_valid", rsp_valid, 2'b01);
        check("rd_rdata", rsp_rdata, 32'd14);
        check("rd_miss", miss_cnt, 1);
        check("rd_hit", hit_cnt, 0);
        cyc();
        check("rd_pulse_once", rsp_valid, 0);
        check("rd_perr", proto_err, 0);

        // Contention: both requesters hold valid for 4 transactions
        doReset();
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cont_grant%0d", k), req_ready, expG[k]);
            cyc();
            check($sformatf("cont_noready%0d", k), req_ready, 0);
            serve(1'b1, DW'(k + 100));
            check($sformatf("cont_rsp%0d", k), rsp_valid, expG[k]);
            check($sformatf("cont_rdata%0d", k), rsp_rdata, k + 100);
        end
        req_valid = '0;
        check("cont_hit_sat", hit_cnt, 3);
        check("cont_miss", miss_cnt, 0);

        // Stall: cache_req_ready low 5 cycles while requester 1 waits
        doReset();
        req_addr[0 +: AW]  = 12'h155;
        req_we[0]          = 1'b1;
        req_wdata[0 +: DW] = 32'h1234_5678;
        req_addr[AW +: AW] = 12'h7F0;
        req_we[1]          = 1'b1;
        req_wdata[DW +: DW] = 32'hDEAD_BEEF;
        req_valid = 2'b01;
        #1;
        check("stall_grant", req_ready, 2'b01);
        cyc();
        req_valid = 2'b10;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_valid%0d", k), cbus.cache_req_valid, 1);
            check($sformatf("stall_addr%0d", k), cbus.cache_addr, 12'h155);
            check($sformatf("stall_we%0d", k), cbus.cache_write_en, 1);
            check($sformatf("stall_ready%0d", k), req_ready, 0);
            cyc();
        end
        serve(1'b0, 32'h1234_5678);
        check("stall_rsp", rsp_valid, 2'b01);
        check("stall_rdata", rsp_rdata, 32'h1234_5678);
        check("stall_miss", miss_cnt, 1);

        // Write by requester 1
        check("wr_grant", req_ready, 2'b10);
        cyc();
        req_valid = '0;
        check("wr_write_en", cbus.cache_write_en, 1);
        check("wr_read_en", cbus.cache_read_en, 0);
        check("wr_wdata", cbus.cache_wdata, 32'hDEAD_BEEF);
        check("wr_addr", cbus.cache_addr, 12'h7F0);
        serve(1'b1, 32'hDEAD_BEEF);
        check("wr_rsp", rsp_valid, 2'b10);
        check("wr_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("wr_hit", hit_cnt, 1);

        // Saturation with 5 hits, then a stray response in IDLE
        doReset();
        req_we = '0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 2'b01;
            #1;
            cyc();
            req_valid = '0;
            serve(1'b1, DW'(k));
        end
        check("sat_hit", hit_cnt, 3);
        check("sat_miss", miss_cnt, 0);
        cbus.cache_rsp_valid = 1'b1;
        cbus.cache_rsp_hit   = 1'b0;
        cyc();
        cbus.cache_rsp_valid = 1'b0;
        check("err_perr", proto_err, 1);
        check("err_hit", hit_cnt, 3);
        check("err_miss", miss_cnt, 0);
        check("err_rsp", rsp_valid, 0);
        check("err_creq", cbus.cache_req_valid, 0);
        cyc();
        check("err_sticky", proto_err, 1);

        // Reset while in WAIT
        doReset();
        check("rw_perr_clr", proto_err, 0);
        check("rw_hit_clr", hit_cnt, 0);
        req_valid = 2'b01;
        #1;
        cyc();
        req_valid = '0;
        cbus.cache_req_ready = 1'b1;
        cyc();
        cbus.cache_req_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rw_creq", cbus.cache_req_valid, 0);
        cbus.cache_rsp_valid = 1'b1;
        cbus.cache_rsp_data  = 32'd99;
        cbus.cache_rsp_hit   = 1'b1;
        cyc();
        cbus.cache_rsp_valid = 1'b0;
        check("rw_no_rsp", rsp_valid, 0);
        check("rw_perr", proto_err, 1);
        check("rw_hit", hit_cnt, 0);
        cyc();
        check("rw_no_rsp2", rsp_valid, 0);
        req_valid = 2'b11;
        #1;
        check("rw_next_grant", req_ready, 2'b01);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
